// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the IF PC and issues one-outstanding
// requests on an addr_ok/data_ok memory port, then hands words to IF/ID.
module if_fetch_ctrl #(
  parameter int unsigned                 INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0]      RESET_PC    = 32'hBFC0_0000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [INSTR_WIDTH-1:0] next_pc,
  input  logic                   redirect,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] flush_pc,
  output logic [INSTR_WIDTH-1:0] pc,
  output logic                   inst_req,
  output logic [INSTR_WIDTH-1:0] inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [INSTR_WIDTH-1:0] inst_rdata,
  output logic                   id_valid,
  output logic [INSTR_WIDTH-1:0] id_pc,
  output logic [INSTR_WIDTH-1:0] id_instr
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [INSTR_WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic                   discard_q, discard_d;
  logic                   redir_pend_q, redir_pend_d;
  logic [INSTR_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic                   id_valid_q, id_valid_d;
  logic [INSTR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [INSTR_WIDTH-1:0] id_instr_q, id_instr_d;

  logic                   accept;
  logic                   handoff;
  logic [INSTR_WIDTH-1:0] handoff_instr;

  assign accept    = !stall || !id_valid_q;
  assign inst_req  = (state_q == ST_REQ);
  assign inst_addr = pc_q;
  assign pc        = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      buf_instr_q  <= '0;
      discard_q    <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      buf_instr_q  <= buf_instr_d;
      discard_q    <= discard_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    buf_instr_d   = buf_instr_q;
    discard_d     = discard_q;
    redir_pend_d  = redir_pend_q;
    redir_pc_d    = redir_pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_instr_d    = id_instr_q;
    handoff       = 1'b0;
    handoff_instr = inst_rdata;

    if (flush) begin
      // A request already accepted must still be drained, hence discard.
      pc_d         = flush_pc;
      id_valid_d   = 1'b0;
      redir_pend_d = 1'b0;
      unique case (state_q)
        ST_RST: state_d = ST_REQ;
        ST_REQ: begin
          if (inst_addr_ok) begin
            state_d   = ST_WAIT;
            discard_d = 1'b1;
          end
        end
        ST_WAIT: begin
          if (inst_data_ok) begin
            state_d   = ST_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        ST_HOLD: state_d = ST_REQ;
        default: state_d = ST_RST;
      endcase
    end else begin
      unique case (state_q)
        ST_RST: state_d = ST_REQ;
        ST_REQ: begin
          if (inst_addr_ok) begin
            req_pc_d = pc_q;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (inst_data_ok) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = ST_REQ;
            end else if (accept) begin
              handoff       = 1'b1;
              handoff_instr = inst_rdata;
              state_d       = ST_REQ;
            end else begin
              buf_instr_d = inst_rdata;
              state_d     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (accept) begin
            handoff       = 1'b1;
            handoff_instr = buf_instr_q;
            state_d       = ST_REQ;
          end
        end
        default: state_d = ST_RST;
      endcase

      // A branch that leaves ID before its delay slot arrives parks its
      // target in redir_pc until the delay slot is handed off.
      if (handoff) begin
        id_valid_d   = 1'b1;
        id_pc_d      = req_pc_q;
        id_instr_d   = handoff_instr;
        pc_d         = redir_pend_q ? redir_pc_q : next_pc;
        redir_pend_d = 1'b0;
      end else if (id_valid_q && !stall) begin
        id_valid_d = 1'b0;
        if (redirect) begin
          redir_pc_d   = next_pc;
          redir_pend_d = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios followed by randomized traffic
// checked every cycle against a transaction-level model using queues.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int assertCount = 0;
  int failCount   = 0;

  if_fetch_ctrl #(.INSTR_WIDTH(32), .RESET_PC(32'hBFC0_0000)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .next_pc      (next_pc),
    .redirect     (redirect),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .pc           (pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_instr     (id_instr)
  );

  always #5 clk = ~clk;

  // Reference model: a fetch is "in flight" from address acceptance until its
  // data returns, then either delivered or parked until ID can take it.
  typedef struct {
    logic [31:0] addr;
    logic        drop;
  } flight_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } parked_t;

  flight_t     inFlight[$];
  parked_t     parked[$];
  logic        mStarted;
  logic [31:0] mPc;
  logic        mIdValid;
  logic [31:0] mIdPc;
  logic [31:0] mIdInstr;
  logic        mPend;
  logic [31:0] mPendPc;

  function automatic logic modelReq();
    return mStarted && inFlight.size() == 0 && parked.size() == 0;
  endfunction

  task automatic modelStep(input logic rstn, input logic [31:0] npc,
                           input logic redir, input logic stl, input logic fl,
                           input logic [31:0] flpc, input logic aok,
                           input logic dok, input logic [31:0] rdata);
    logic        requesting;
    logic        canTake;
    logic        delivered;
    logic [31:0] dAddr;
    logic [31:0] dInstr;
    flight_t     f;
    parked_t     p;
    if (!rstn) begin
      inFlight.delete();
      parked.delete();
      mStarted = 1'b0;
      mPc      = 32'hBFC0_0000;
      mIdValid = 1'b0;
      mIdPc    = '0;
      mIdInstr = '0;
      mPend    = 1'b0;
      mPendPc  = '0;
      return;
    end
    requesting = modelReq();
    canTake    = !stl || !mIdValid;
    delivered  = 1'b0;
    dAddr      = '0;
    dInstr     = '0;
    if (fl) begin
      if (requesting && aok) begin
        f.addr = mPc;
        f.drop = 1'b1;
        inFlight.push_back(f);
      end else if (inFlight.size() != 0) begin
        if (dok) inFlight.delete();
        else inFlight[0].drop = 1'b1;
      end else if (parked.size() != 0) begin
        parked.delete();
      end
      mPc      = flpc;
      mIdValid = 1'b0;
      mPend    = 1'b0;
    end else begin
      if (requesting && aok) begin
        f.addr = mPc;
        f.drop = 1'b0;
        inFlight.push_back(f);
      end else if (inFlight.size() != 0 && dok) begin
        f = inFlight.pop_front();
        if (!f.drop) begin
          if (canTake) begin
            delivered = 1'b1;
            dAddr     = f.addr;
            dInstr    = rdata;
          end else begin
            p.addr  = f.addr;
            p.instr = rdata;
            parked.push_back(p);
          end
        end
      end else if (parked.size() != 0 && canTake) begin
        p         = parked.pop_front();
        delivered = 1'b1;
        dAddr     = p.addr;
        dInstr    = p.instr;
      end
      if (delivered) begin
        mIdValid = 1'b1;
        mIdPc    = dAddr;
        mIdInstr = dInstr;
        mPc      = mPend ? mPendPc : npc;
        mPend    = 1'b0;
      end else if (mIdValid && !stl) begin
        mIdValid = 1'b0;
        if (redir) begin
          mPendPc = npc;
          mPend   = 1'b1;
        end
      end
    end
    mStarted = 1'b1;
  endtask

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the model on the same edge, then
  // compares every DUT output against the model just after the edge.
  task automatic applyStimulus(input logic rstn, input logic [31:0] npc,
                               input logic redir, input logic stl,
                               input logic fl, input logic [31:0] flpc,
                               input logic aok, input logic dok,
                               input logic [31:0] rdata);
    @(negedge clk);
    resetn       = rstn;
    next_pc      = npc;
    redirect     = redir;
    stall        = stl;
    flush        = fl;
    flush_pc     = flpc;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rdata;
    @(posedge clk);
    modelStep(rstn, npc, redir, stl, fl, flpc, aok, dok, rdata);
    #1;
    checkOutput("inst_req",  {31'd0, inst_req}, {31'd0, modelReq()});
    checkOutput("pc",        pc,                 mPc);
    checkOutput("inst_addr", inst_addr,          mPc);
    checkOutput("id_valid",  {31'd0, id_valid},  {31'd0, mIdValid});
    checkOutput("id_pc",     id_pc,              mIdPc);
    checkOutput("id_instr",  id_instr,           mIdInstr);
  endtask

  // Shorthand for directed cycles without reset or flush.
  task automatic runCycle(input logic [31:0] npc, input logic redir,
                          input logic stl, input logic aok, input logic dok,
                          input logic [31:0] rdata);
    applyStimulus(1'b1, npc, redir, stl, 1'b0, 32'd0, aok, dok, rdata);
  endtask

  logic        memBusy;
  int          memDelay;
  logic [31:0] memAddr;

  initial begin
    logic        rRstn, rRedir, rStall, rFlush, rAok, rDok;
    logic [31:0] rNpc, rFlPc, rData, reqPc;

    resetn = 1'b0; next_pc = '0; redirect = 1'b0; stall = 1'b0;
    flush = 1'b0; flush_pc = '0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    inst_rdata = '0;

    // Reset, release, first fetch
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_req",   {31'd0, inst_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, id_valid}, 32'd0);
    runCycle(32'hBFC0_0004, 0, 0, 0, 0, 0);
    checkOutput("first_req",  {31'd0, inst_req}, 32'd1);
    checkOutput("first_addr", inst_addr, 32'hBFC0_0000);
    runCycle(32'hBFC0_0004, 0, 0, 1, 0, 0);
    runCycle(32'hBFC0_0004, 0, 0, 0, 1, 32'h2408_0001);
    checkOutput("ho_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("ho_pc",    id_pc,    32'hBFC0_0000);
    checkOutput("ho_instr", id_instr, 32'h2408_0001);
    checkOutput("ho_newpc", pc,       32'hBFC0_0004);
    checkOutput("ho_req",   {31'd0, inst_req}, 32'd1);

    // Stall while data returns: buffer, then release
    runCycle(32'hBFC0_0008, 0, 1, 1, 0, 0);
    runCycle(32'hBFC0_0008, 0, 1, 0, 1, 32'h8C09_0000);
    checkOutput("hold_instr", id_instr, 32'h2408_0001);
    checkOutput("hold_pc",    pc,       32'hBFC0_0004);
    runCycle(32'hBFC0_0008, 0, 0, 0, 0, 0);
    checkOutput("unhold_instr", id_instr, 32'h8C09_0000);
    checkOutput("unhold_pc",    pc,       32'hBFC0_0008);

    // Branch leaves ID before its delay slot arrives
    runCycle(32'hBFC0_000C, 0, 1, 1, 0, 0);
    runCycle(32'hBFC0_0100, 1, 0, 0, 0, 0);
    checkOutput("bub_valid", {31'd0, id_valid}, 32'd0);
    runCycle(32'hBFC0_000C, 0, 0, 0, 1, 32'h0000_0000);
    checkOutput("ds_pc",     id_pc, 32'hBFC0_0008);
    checkOutput("ds_target", pc,    32'hBFC0_0100);

    // Flush during WAIT, stale data dropped
    runCycle(32'hBFC0_0104, 0, 0, 1, 0, 0);
    applyStimulus(1'b1, 32'hBFC0_0104, 0, 0, 1'b1, 32'hBFC0_0380, 0, 0, 0);
    runCycle(32'hBFC0_0104, 0, 0, 0, 0, 0);
    runCycle(32'hBFC0_0104, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("fl_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("fl_addr",  inst_addr, 32'hBFC0_0380);
    checkOutput("fl_instr", id_instr,  32'h0000_0000);

    // Reset while holding
    runCycle(32'hBFC0_0384, 0, 0, 1, 0, 0);
    runCycle(32'hBFC0_0384, 0, 0, 0, 1, 32'h1111_2222);
    runCycle(32'hBFC0_0388, 0, 1, 1, 0, 0);
    runCycle(32'hBFC0_0388, 0, 1, 0, 1, 32'h3333_4444);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rh_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("rh_pc",    pc, 32'hBFC0_0000);
    runCycle(32'hBFC0_0004, 0, 0, 0, 0, 0);
    checkOutput("rh_refetch", inst_addr, 32'hBFC0_0000);

    // Randomized traffic against a memory with 1..3 cycle data latency
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    memBusy = 1'b0; memDelay = 0; memAddr = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rRstn  = ($urandom_range(0, 199) != 0);
      rFlush = ($urandom_range(0, 24) == 0);
      rFlPc  = $urandom & 32'hFFFF_FFFC;
      rStall = ($urandom_range(0, 2) == 0);
      rRedir = ($urandom_range(0, 3) == 0);
      rNpc   = $urandom & 32'hFFFF_FFFC;
      rAok   = modelReq() && ($urandom_range(0, 3) != 0);
      if (memBusy) begin
        rDok  = (memDelay == 0);
        rData = memAddr ^ 32'h5A5A_0F0F;
      end else begin
        rDok  = ($urandom_range(0, 9) == 0);
        rData = $urandom;
      end
      reqPc = mPc;
      applyStimulus(rRstn, rNpc, rRedir, rStall, rFlush, rFlPc, rAok, rDok, rData);
      if (!rRstn) begin
        memBusy = 1'b0;
      end else if (rAok) begin
        memBusy  = 1'b1;
        memDelay = $urandom_range(0, 2);
        memAddr  = reqPc;
      end else if (memBusy) begin
        if (rDok) memBusy = 1'b0;
        else memDelay--;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
